fifo_wr_serializer: RTL and testbench

Write-side feeder for the byte-wide asynchronous FIFO, running entirely in the clk_write domain. It accepts multi-byte words on a valid/ready stream and breaks them into single bytes. Each byte is driven onto the FIFO write port (wr_en/wr_data) only while the FIFO reports not-full. It also supports byte-lane masking, packet-end marking and write statistics.

---
 rtl/fifo_wr_serializer_if.sv | 33 +++
 rtl/fifo_wr_serializer.sv | 159 +++++++++++++++
 tb/tb_fifo_wr_serializer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_serializer_if.sv
// Purpose: bundles the word stream, the byte-FIFO write port and the status outputs of fifo_wr_serializer.
// Latency: none (wiring only).
// Backpressure: s_ready from slave to master; fifo_full from the FIFO to the slave.
// Ports: s_valid/s_ready/s_data/s_keep/s_last = input word stream;
//        fifo_full/fifo_wr_en/fifo_wr_data = byte FIFO write side;
//        busy/pkt_done/byte_count = status.
interface fifo_wr_serializer_if #(
  parameter int IN_BYTES = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic [8*IN_BYTES-1:0] s_data;
  logic [IN_BYTES-1:0]   s_keep;
  logic                  s_last;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [7:0]            fifo_wr_data;
  logic                  busy;
  logic                  pkt_done;
  logic [15:0]           byte_count;

  // slave = the serializer itself
  modport slave (
    input  s_valid, s_data, s_keep, s_last, fifo_full,
    output s_ready, fifo_wr_en, fifo_wr_data, busy, pkt_done, byte_count
  );

  // master = word source plus FIFO model
  modport master (
    output s_valid, s_data, s_keep, s_last, fifo_full,
    input  s_ready, fifo_wr_en, fifo_wr_data, busy, pkt_done, byte_count
  );
endinterface

// File: rtl/fifo_wr_serializer.sv
// Purpose: splits IN_BYTES-wide words into kept bytes and writes them to a byte-wide FIFO (clk_write domain).
// Latency: first byte is written in the cycle after the word transfer; one IDLE cycle between words.
// Backpressure: s_ready only in IDLE; byte writes stall (lane and data held) while fifo_full is high.
// Ports: clk_write, rst (async, active-high), bus (fifo_wr_serializer_if.slave).
// Option: define FIFO_WR_SERIALIZER_CHECKSUM_EN to append a mod-256 byte sum after each packet.
module fifo_wr_serializer #(
  parameter int IN_BYTES  = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk_write,
  input  logic                rst,
  fifo_wr_serializer_if.slave bus
);

  localparam int LW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

  state_t                   state_q, state_d;
  logic [IN_BYTES-1:0][7:0] data_q, data_d;
  logic [IN_BYTES-1:0]      keep_q, keep_d;   // lanes not yet written
  logic                     last_q, last_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     empty_done_q, empty_done_d;
  logic [IN_BYTES-1:0]      keep_left;
  logic                     wr_en;
  logic                     final_byte;
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
  logic [7:0]               acc_q, acc_d;
`endif

  // First set lane of m in emit order: highest lane when MSB_FIRST, else lowest.
  function automatic logic [LW-1:0] first_lane(input logic [IN_BYTES-1:0] m);
    logic [LW-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < IN_BYTES; i++) if (m[i]) r = LW'(i);
    end else begin
      for (int i = IN_BYTES - 1; i >= 0; i--) if (m[i]) r = LW'(i);
    end
    return r;
  endfunction

  // Every non-IDLE state is a write state, so the strobe follows the state
  // register and drops asynchronously with rst.
  assign wr_en          = (state_q != IDLE) & ~bus.fifo_full;
  assign bus.fifo_wr_en = wr_en;
  assign bus.s_ready    = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.byte_count = cnt_q;
  // Written-byte completions are combinational; an empty last word has no
  // write, so its completion comes from a one-cycle flag instead.
  assign bus.pkt_done   = final_byte | empty_done_q;

  always_comb begin
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
    bus.fifo_wr_data = (state_q == CSUM) ? acc_q : data_q[lane_q];
`else
    bus.fifo_wr_data = data_q[lane_q];
`endif
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    lane_d       = lane_q;
    empty_done_d = 1'b0;
    final_byte   = 1'b0;
    cnt_d        = cnt_q + 16'(wr_en);
    keep_left    = keep_q & ~(IN_BYTES'(1) << lane_q);
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
    acc_d        = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          data_d = bus.s_data;
          keep_d = bus.s_keep;
          last_d = bus.s_last;
          lane_d = first_lane(bus.s_keep);
          if (bus.s_keep != '0) begin
            state_d = SEND;
          end else if (bus.s_last) begin
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
            state_d = CSUM;
`else
            empty_done_d = 1'b1;
`endif
          end
        end
      end
      SEND: begin
        if (wr_en) begin
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
          acc_d = acc_q + data_q[lane_q];
`endif
          keep_d = keep_left;
          lane_d = first_lane(keep_left);
          if (keep_left == '0) begin
            if (last_q) begin
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
              state_d = CSUM;
`else
              final_byte = 1'b1;
              state_d    = IDLE;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
      CSUM: begin
        if (wr_en) begin
          final_byte = 1'b1;
          acc_d      = 8'h00;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      lane_q       <= '0;
      cnt_q        <= 16'h0000;
      empty_done_q <= 1'b0;
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
      acc_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      empty_done_q <= empty_done_d;
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
      acc_q        <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Purpose: checks fifo_wr_serializer (MSB-first and LSB-first instances in lockstep) against a byte-list model.
// Latency: n/a.
// Backpressure: fifo_full driven directly and randomly.
module tb_fifo_wr_serializer;
  localparam int IN_BYTES = 4;
`ifdef FIFO_WR_SERIALIZER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] bm;    // expected byte, MSB-first instance
    logic [7:0] bl;    // expected byte, LSB-first instance
    logic       done;  // pkt_done expected with this write
  } exp_t;

  logic        clk_write = 1'b0;
  logic        rst = 1'b1;
  logic        full_force = 1'b0;
  logic        full_rand = 1'b0;
  logic        full_rnd = 1'b0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  psum = 8'h00;
  logic [15:0] model_cnt = 16'h0000;
  int          exp_empty = 0;
  int          nowrite_m = 0;
  int          nowrite_l = 0;

  always #5 clk_write = ~clk_write;

  fifo_wr_serializer_if #(.IN_BYTES(IN_BYTES)) bus_m ();
  fifo_wr_serializer_if #(.IN_BYTES(IN_BYTES)) bus_l ();

  assign bus_m.fifo_full = full_force | full_rnd;
  assign bus_l.fifo_full = bus_m.fifo_full;
  assign bus_l.s_valid   = bus_m.s_valid;
  assign bus_l.s_data    = bus_m.s_data;
  assign bus_l.s_keep    = bus_m.s_keep;
  assign bus_l.s_last    = bus_m.s_last;

  fifo_wr_serializer #(.IN_BYTES(IN_BYTES), .MSB_FIRST(1'b1)) dut_m (
    .clk_write (clk_write),
    .rst       (rst),
    .bus       (bus_m)
  );

  fifo_wr_serializer #(.IN_BYTES(IN_BYTES), .MSB_FIRST(1'b0)) dut_l (
    .clk_write (clk_write),
    .rst       (rst),
    .bus       (bus_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every FIFO write must match the head of the expected byte list.
  always @(negedge clk_write) begin
    if (!rst) begin
      if (bus_m.fifo_full) check("wr_while_full", bus_m.fifo_wr_en, 0);
      if (bus_m.fifo_wr_en) begin
        check("rdy_in_write", bus_m.s_ready, 0);
        check("busy_in_write", bus_m.busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_m", bus_m.fifo_wr_data, mon_e.bm);
          check("data_l", bus_l.fifo_wr_data, mon_e.bl);
          check("wr_en_l", bus_l.fifo_wr_en, 1);
          check("done_m", bus_m.pkt_done, mon_e.done);
          check("done_l", bus_l.pkt_done, mon_e.done);
        end
      end else begin
        check("idle_wr_en_l", bus_l.fifo_wr_en, 0);
        if (bus_m.pkt_done) nowrite_m++;
      end
      if (!bus_l.fifo_wr_en && bus_l.pkt_done) nowrite_l++;
    end
  end

  // Random backpressure, enabled only in the random phase.
  initial begin
    forever begin
      @(posedge clk_write);
      #1;
      full_rnd = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    psum          = 8'h00;
    model_cnt     = 16'h0000;
    bus_m.s_valid = 1'b0;
    full_force    = 1'b0;
    repeat (2) @(posedge clk_write);
    #2 rst = 1'b0;
    @(posedge clk_write);
    #1;
  endtask

  // Waits for s_ready, builds the expected byte list for this word, then transfers it.
  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [7:0] bm[$];
    logic [7:0] bl[$];
    exp_t       e;
    int         guard;
    guard = 0;
    while (!bus_m.s_ready && guard < 200) begin
      @(posedge clk_write);
      #1;
      guard++;
    end
    if (!bus_m.s_ready) check("ready_timeout", bus_m.s_ready, 1);
    for (int i = IN_BYTES - 1; i >= 0; i--) if (k[i]) bm.push_back(d[8*i +: 8]);
    for (int i = 0; i < IN_BYTES; i++) if (k[i]) bl.push_back(d[8*i +: 8]);
    for (int j = 0; j < bm.size(); j++) begin
      e.bm   = bm[j];
      e.bl   = bl[j];
      e.done = l && (j == bm.size() - 1) && !CSUM;
      exp_q.push_back(e);
      psum      = psum + bm[j];
      model_cnt = model_cnt + 16'd1;
    end
    if (l) begin
      if (CSUM) begin
        e.bm = psum;
        e.bl = psum;
        e.done = 1'b1;
        exp_q.push_back(e);
        model_cnt = model_cnt + 16'd1;
        psum      = 8'h00;
      end else if (bm.size() == 0) begin
        exp_empty++;
      end
    end
    bus_m.s_valid = 1'b1;
    bus_m.s_data  = d;
    bus_m.s_keep  = k;
    bus_m.s_last  = l;
    @(posedge clk_write);
    #1;
    bus_m.s_valid = 1'b0;
  endtask

  // Expects n back-to-back writes starting next cycle, then a return to IDLE.
  task automatic expect_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_write);
      check("burst_wr_en", bus_m.fifo_wr_en, 1);
    end
    @(negedge clk_write);
    check("burst_end_wr_en", bus_m.fifo_wr_en, 0);
    check("burst_end_ready", bus_m.s_ready, 1);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    @(negedge clk_write);
    while ((exp_q.size() != 0 || !bus_m.s_ready) && guard < 500) begin
      @(negedge clk_write);
      guard++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_cnt_m"}, bus_m.byte_count, model_cnt);
    check({tag, "_cnt_l"}, bus_l.byte_count, model_cnt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int guard;
    int seen;
    bus_m.s_valid = 1'b0;
    bus_m.s_data  = '0;
    bus_m.s_keep  = '0;
    bus_m.s_last  = 1'b0;

    // Reset state, both during and right after reset.
    #3;
    check("rst_ready", bus_m.s_ready, 1);
    check("rst_wr_en", bus_m.fifo_wr_en, 0);
    do_reset();
    @(negedge clk_write);
    check("init_ready", bus_m.s_ready, 1);
    check("init_wr_en", bus_m.fifo_wr_en, 0);
    check("init_busy", bus_m.busy, 0);
    check("init_done", bus_m.pkt_done, 0);
    check("init_cnt", bus_m.byte_count, 0);
    check("init_data", bus_m.fifo_wr_data, 0);

    // Full word, all lanes kept.
    do_reset();
    send_word(32'hA1B2C3D4, 4'b1111, 1'b0);
    expect_burst(4);
    drain("t1");
    check("t1_cnt", bus_m.byte_count, 4);

    // Sparse keep: B2,D4 (MSB first) and D4,B2 (LSB first).
    do_reset();
    send_word(32'hA1B2C3D4, 4'b0101, 1'b0);
    expect_burst(2);
    drain("t2");
    check("t2_cnt", bus_m.byte_count, 2);

    // Three-cycle stall right after B2 is written.
    do_reset();
    send_word(32'hA1B2C3D4, 4'b1111, 1'b0);
    guard = 0;
    while (!(bus_m.fifo_wr_en && bus_m.fifo_wr_data == 8'hB2) && guard < 20) begin
      @(negedge clk_write);
      guard++;
    end
    check("t3_saw_b2", bus_m.fifo_wr_data, 8'hB2);
    @(posedge clk_write);
    #1 full_force = 1'b1;
    repeat (3) begin
      @(negedge clk_write);
      check("t3_stall_wr_en", bus_m.fifo_wr_en, 0);
      check("t3_stall_data", bus_m.fifo_wr_data, 8'hC3);
      @(posedge clk_write);
      #1;
    end
    full_force = 1'b0;
    drain("t3");
    check("t3_cnt", bus_m.byte_count, 4);

    // Two-word packet: checksum byte 0x09 appended in the checksum build.
    do_reset();
    send_word(32'h01020304, 4'b1111, 1'b0);
    send_word(32'h000000FF, 4'b0001, 1'b1);
    drain("t4");
    check("t4_cnt", bus_m.byte_count, CSUM ? 6 : 5);

    // Reset after two of four bytes: strobe must drop without a clock edge.
    do_reset();
    send_word(32'hA1B2C3D4, 4'b1111, 1'b0);
    seen  = 0;
    guard = 0;
    while (seen < 2 && guard < 50) begin
      @(negedge clk_write);
      if (bus_m.fifo_wr_en) seen++;
      guard++;
    end
    check("t5_two_writes", seen, 2);
    @(posedge clk_write);
    #2 rst = 1'b1;
    #1;
    check("t5_async_wr_en", bus_m.fifo_wr_en, 0);
    check("t5_async_wr_en_l", bus_l.fifo_wr_en, 0);
    exp_q.delete();
    psum      = 8'h00;
    model_cnt = 16'h0000;
    repeat (2) @(posedge clk_write);
    #2 rst = 1'b0;
    @(negedge clk_write);
    check("t5_ready", bus_m.s_ready, 1);
    check("t5_cnt", bus_m.byte_count, 0);
    repeat (8) @(negedge clk_write);
    drain("t5");

    // Empty words: discarded, or an end-of-packet marker.
    do_reset();
    send_word(32'h12345678, 4'b0000, 1'b0);
    @(negedge clk_write);
    check("t6_ready", bus_m.s_ready, 1);
    check("t6_no_wr", bus_m.fifo_wr_en, 0);
    send_word(32'h00000000, 4'b0000, 1'b1);
    @(negedge clk_write);
    check("t6_done_pulse", bus_m.pkt_done, 1);
    @(negedge clk_write);
    check("t6_done_single", bus_m.pkt_done, 0);
    drain("t6");

    // Random words under random backpressure.
    do_reset();
    full_rand = 1'b1;
    for (int w = 0; w < 300; w++) begin
      send_word($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_write);
      #1;
    end
    full_rand = 1'b0;
    drain("rand");

    check("empty_done_m", nowrite_m, exp_empty);
    check("empty_done_l", nowrite_l, exp_empty);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
